// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel divider, H/V counters and registered sync/active decode
module vga_sync_gen #(
   parameter int   DIV      = 4,
   parameter int   H_BP     = 48,
   parameter int   H_ACT    = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   V_BP     = 35,
   parameter int   V_ACT    = 480,
   parameter int   V_FP     = 8,
   parameter int   V_SYNC   = 2,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       reloj,
   input  logic       resetM,
   input  logic       en,
   output logic [9:0] Qh,
   output logic [9:0] Qv,
   output logic       H_ON,
   output logic       V_ON,
   output logic       hsync,
   output logic       vsync,
   output logic       pixel_tick,
   output logic       frame_start
);

   // Counter origin is the start of the back porch, so the line is laid out
   // as back porch, active, front porch, sync.
   localparam int H_TOTAL = H_BP + H_ACT + H_FP + H_SYNC;
   localparam int V_TOTAL = V_BP + V_ACT + V_FP + V_SYNC;

   // All decode boundaries held as full 10-bit constants so every compare is
   // done at counter width without truncation of the counter itself.
   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ON_FIRST   = 10'(H_BP);
   localparam logic [9:0] H_ON_LAST    = 10'(H_BP + H_ACT - 1);
   localparam logic [9:0] V_ON_FIRST   = 10'(V_BP);
   localparam logic [9:0] V_ON_LAST    = 10'(V_BP + V_ACT - 1);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_BP + H_ACT + H_FP);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_BP + V_ACT + V_FP);

   localparam int                DIV_W    = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [9:0]       qh_nxt;
   logic [9:0]       qv_nxt;
   logic             h_on_nxt;
   logic             v_on_nxt;
   logic             h_sync_act;
   logic             v_sync_act;
   logic             frame_wrap;

   // Pixel-rate divider: free-runs 0..DIV-1 while enabled, frozen otherwise.
   always_ff @(posedge reloj or posedge resetM) begin
      if (resetM) begin
         div_cnt <= '0;
      end else if (en) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // A disabled cycle never ticks, even if the divider sits on its last count.
   assign tick = en && (div_cnt == DIV_LAST);

   // Next counter values; the vertical counter only moves on the horizontal wrap.
   always_comb begin
      qh_nxt = Qh;
      qv_nxt = Qv;
      if (Qh == H_LAST) begin
         qh_nxt = '0;
         if (Qv == V_LAST) begin
            qv_nxt = '0;
         end else begin
            qv_nxt = Qv + 10'd1;
         end
      end else begin
         qh_nxt = Qh + 10'd1;
      end
   end

   // Decode from the next counter values so the registered flags line up with Qh/Qv.
   always_comb begin
      h_on_nxt   = (qh_nxt >= H_ON_FIRST) && (qh_nxt <= H_ON_LAST);
      v_on_nxt   = (qv_nxt >= V_ON_FIRST) && (qv_nxt <= V_ON_LAST);
      h_sync_act = (qh_nxt >= H_SYNC_FIRST);
      v_sync_act = (qv_nxt >= V_SYNC_FIRST);
      frame_wrap = (qh_nxt == 10'd0) && (qv_nxt == 10'd0);
   end

   // Counters, active flags and syncs advance together, once per tick.
   always_ff @(posedge reloj or posedge resetM) begin
      if (resetM) begin
         Qh    <= '0;
         Qv    <= '0;
         H_ON  <= 1'b0;
         V_ON  <= 1'b0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
      end else if (tick) begin
         Qh    <= qh_nxt;
         Qv    <= qv_nxt;
         H_ON  <= h_on_nxt;
         V_ON  <= v_on_nxt;
         hsync <= h_sync_act ? SYNC_POL : ~SYNC_POL;
         vsync <= v_sync_act ? SYNC_POL : ~SYNC_POL;
      end
   end

   // Single-cycle strobes; both drop whenever no tick happens, including while disabled.
   always_ff @(posedge reloj or posedge resetM) begin
      if (resetM) begin
         pixel_tick  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pixel_tick  <= tick;
         frame_start <= tick && frame_wrap;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

   localparam int DIV_D = 4;
   localparam int DIV_S = 2;

   logic       reloj = 1'b0;
   logic       rst_d = 1'b0;
   logic       en_d  = 1'b0;
   logic       rst_s = 1'b0;
   logic       en_s  = 1'b0;

   logic [9:0] qh_d, qv_d, qh_s, qv_s;
   logic       hon_d, von_d, hs_d, vs_d, pt_d, fs_d;
   logic       hon_s, von_s, hs_s, vs_s, pt_s, fs_s;

   int checks = 0;
   int errors = 0;

   always #5 reloj = ~reloj;

   vga_sync_gen #(.DIV(DIV_D)) dut_d (
      .reloj(reloj), .resetM(rst_d), .en(en_d),
      .Qh(qh_d), .Qv(qv_d), .H_ON(hon_d), .V_ON(von_d),
      .hsync(hs_d), .vsync(vs_d), .pixel_tick(pt_d), .frame_start(fs_d)
   );

   vga_sync_gen #(
      .DIV(DIV_S), .H_BP(2), .H_ACT(4), .H_FP(1), .H_SYNC(1),
      .V_BP(1), .V_ACT(2), .V_FP(1), .V_SYNC(1), .SYNC_POL(1'b1)
   ) dut_s (
      .reloj(reloj), .resetM(rst_s), .en(en_s),
      .Qh(qh_s), .Qv(qv_s), .H_ON(hon_s), .V_ON(von_s),
      .hsync(hs_s), .vsync(vs_s), .pixel_tick(pt_s), .frame_start(fs_s)
   );

   // Reference: outputs follow from the number of enabled cycles since reset.
   function automatic logic [25:0] expect_out(int e, bit tk, int div,
                                              int hbp, int hact, int hfp, int hsy,
                                              int vbp, int vact, int vfp, int vsy, bit pol);
      int n, ht, vt, qh, qv;
      logic hon, von, hs, vs, fs;
      n   = e / div;
      ht  = hbp + hact + hfp + hsy;
      vt  = vbp + vact + vfp + vsy;
      qh  = n % ht;
      qv  = (n / ht) % vt;
      hon = (qh >= hbp) && (qh < hbp + hact);
      von = (qv >= vbp) && (qv < vbp + vact);
      hs  = (qh >= hbp + hact + hfp) ? pol : ~pol;
      vs  = (qv >= vbp + vact + vfp) ? pol : ~pol;
      fs  = tk && ((n % (ht * vt)) == 0);
      return {qh[9:0], qv[9:0], hon, von, hs, vs, tk, fs};
   endfunction

   int e_d = 0;
   int e_s = 0;
   bit tk_d = 1'b0;
   bit tk_s = 1'b0;

   always @(posedge reloj or posedge rst_d) begin
      if (rst_d) begin
         e_d <= 0; tk_d <= 1'b0;
      end else if (en_d) begin
         e_d <= e_d + 1; tk_d <= (((e_d + 1) % DIV_D) == 0);
      end else begin
         tk_d <= 1'b0;
      end
   end

   always @(posedge reloj or posedge rst_s) begin
      if (rst_s) begin
         e_s <= 0; tk_s <= 1'b0;
      end else if (en_s) begin
         e_s <= e_s + 1; tk_s <= (((e_s + 1) % DIV_S) == 0);
      end else begin
         tk_s <= 1'b0;
      end
   end

   logic [25:0] obs_d, exp_d, obs_s, exp_s;
   assign obs_d = {qh_d, qv_d, hon_d, von_d, hs_d, vs_d, pt_d, fs_d};
   assign obs_s = {qh_s, qv_s, hon_s, von_s, hs_s, vs_s, pt_s, fs_s};
   assign exp_d = expect_out(e_d, tk_d, DIV_D, 48, 640, 16, 96, 35, 480, 8, 2, 1'b0);
   assign exp_s = expect_out(e_s, tk_s, DIV_S, 2, 4, 1, 1, 1, 2, 1, 1, 1'b1);

   task automatic test_reset();
      #1;
      rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
      #1;
      checks++;
      if (obs_d !== {10'd0, 10'd0, 6'b001100}) begin
         errors++; $display("FAIL reset_default got %h exp %h", obs_d, {10'd0, 10'd0, 6'b001100});
      end
      checks++;
      if (obs_s !== {10'd0, 10'd0, 6'b000000}) begin
         errors++; $display("FAIL reset_small got %h exp %h", obs_s, {10'd0, 10'd0, 6'b000000});
      end
      checks++;
      if (obs_d !== exp_d) begin
         errors++; $display("FAIL reset_model got %h exp %h", obs_d, exp_d);
      end
   endtask

   task automatic test_first_ticks();
      int first_pt = -1;
      @(negedge reloj);
      rst_d = 1'b0; en_d = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL first_model cyc=%0d got %h exp %h", cyc, obs_d, exp_d);
         end
         checks++;
         if (pt_d !== ((cyc % DIV_D) == 0)) begin
            errors++; $display("FAIL first_tick_spacing cyc=%0d got %b", cyc, pt_d);
         end
         if (pt_d && first_pt < 0) first_pt = cyc;
         if (cyc == 4) begin
            checks++;
            if ({qh_d, hs_d, vs_d} !== {10'd1, 1'b1, 1'b1}) begin
               errors++; $display("FAIL first_tick_qh got qh=%0d hs=%b vs=%b exp 1 1 1", qh_d, hs_d, vs_d);
            end
         end
         if (cyc == 8) begin
            checks++;
            if (qh_d !== 10'd2) begin
               errors++; $display("FAIL second_tick_qh got %0d exp 2", qh_d);
            end
         end
      end
      checks++;
      if (first_pt != 4) begin
         errors++; $display("FAIL first_tick_cycle got %0d exp 4", first_pt);
      end
   endtask

   task automatic test_one_line();
      int hon_ticks = 0, hs_low = 0, rises = 0, falls = 0, wraps = 0;
      logic prev_hon;
      logic [9:0] prev_qh, prev_qv;
      prev_hon = hon_d; prev_qh = qh_d; prev_qv = qv_d;
      for (int cyc = 0; cyc < 3300; cyc++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL line_model cyc=%0d got %h exp %h", cyc, obs_d, exp_d);
         end
         if (hon_d && !prev_hon) begin
            rises++; checks++;
            if (qh_d !== 10'd48) begin
               errors++; $display("FAIL hon_rise got qh=%0d exp 48", qh_d);
            end
         end
         if (!hon_d && prev_hon) begin
            falls++; checks++;
            if (qh_d !== 10'd688) begin
               errors++; $display("FAIL hon_fall got qh=%0d exp 688", qh_d);
            end
         end
         if (prev_qh == 10'd799 && qh_d != 10'd799) begin
            wraps++; checks++;
            if ({qh_d, qv_d} !== {10'd0, prev_qv + 10'd1}) begin
               errors++; $display("FAIL h_wrap got qh=%0d qv=%0d exp 0 %0d", qh_d, qv_d, prev_qv + 10'd1);
            end
         end
         if (pt_d && hon_d) hon_ticks++;
         if (!hs_d) hs_low++;
         prev_hon = hon_d; prev_qh = qh_d; prev_qv = qv_d;
      end
      checks++;
      if (hon_ticks != 640) begin errors++; $display("FAIL hon_width got %0d exp 640", hon_ticks); end
      checks++;
      if (hs_low != 384) begin errors++; $display("FAIL hsync_width got %0d exp 384", hs_low); end
      checks++;
      if (rises != 1 || falls != 1 || wraps != 1) begin
         errors++; $display("FAIL line_edges got r=%0d f=%0d w=%0d exp 1 1 1", rises, falls, wraps);
      end
   endtask

   task automatic test_enable_hold();
      int guard = 0;
      int seen = 0;
      logic [25:0] held;
      while (!(qh_d == 10'd100 && pt_d) && guard < 4000) begin
         @(negedge reloj); guard++;
      end
      checks++;
      if (!(qh_d == 10'd100 && pt_d)) begin
         errors++; $display("FAIL hold_reach got qh=%0d exp 100 within 4000", qh_d);
      end
      held = obs_d;
      en_d = 1'b0;
      for (int c = 0; c < 37; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== {held[25:2], 2'b00}) begin
            errors++; $display("FAIL hold_freeze c=%0d got %h exp %h", c, obs_d, {held[25:2], 2'b00});
         end
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL hold_model c=%0d got %h exp %h", c, obs_d, exp_d);
         end
      end
      en_d = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL resume_model c=%0d got %h exp %h", c, obs_d, exp_d);
         end
         if (qh_d == 10'd101 && seen == 0) seen = c;
      end
      checks++;
      if (seen != DIV_D) begin
         errors++; $display("FAIL resume_spacing got %0d exp %0d", seen, DIV_D);
      end
   endtask

   task automatic test_random_enable();
      for (int c = 0; c < 1500; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL rand_en_model c=%0d got %h exp %h", c, obs_d, exp_d);
         end
         en_d = ($urandom_range(0, 3) != 0);
      end
      en_d = 1'b1;
   endtask

   task automatic test_async_reset();
      int guard = 0;
      while (qh_d != 10'd300 && guard < 8000) begin
         @(negedge reloj); guard++;
      end
      checks++;
      if (qh_d !== 10'd300) begin
         errors++; $display("FAIL areset_reach got qh=%0d exp 300 within 8000", qh_d);
      end
      #2;
      rst_d = 1'b1;
      #1;
      checks++;
      if (obs_d !== {10'd0, 10'd0, 6'b001100}) begin
         errors++; $display("FAIL areset_values got %h exp %h", obs_d, {10'd0, 10'd0, 6'b001100});
      end
      @(negedge reloj);
      rst_d = 1'b0; en_d = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_d !== exp_d) begin
            errors++; $display("FAIL areset_restart c=%0d got %h exp %h", c, obs_d, exp_d);
         end
         if (c == 4) begin
            checks++;
            if ({qh_d, pt_d} !== {10'd1, 1'b1}) begin
               errors++; $display("FAIL areset_first_tick got qh=%0d pt=%b exp 1 1", qh_d, pt_d);
            end
         end
      end
   endtask

   task automatic test_small_frame();
      int fs_cnt = 0;
      logic [9:0] maxqh = '0, maxqv = '0;
      @(negedge reloj);
      rst_s = 1'b0; en_s = 1'b1;
      for (int c = 0; c < 240; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_s !== exp_s) begin
            errors++; $display("FAIL small_model c=%0d got %h exp %h", c, obs_s, exp_s);
         end
         checks++;
         if (hs_s !== (qh_s == 10'd7)) begin
            errors++; $display("FAIL small_hsync qh=%0d got %b", qh_s, hs_s);
         end
         checks++;
         if (vs_s !== (qv_s == 10'd4)) begin
            errors++; $display("FAIL small_vsync qv=%0d got %b", qv_s, vs_s);
         end
         checks++;
         if ({hon_s, von_s} !== {(qh_s >= 10'd2 && qh_s <= 10'd5), (qv_s >= 10'd1 && qv_s <= 10'd2)}) begin
            errors++; $display("FAIL small_active qh=%0d qv=%0d got %b%b", qh_s, qv_s, hon_s, von_s);
         end
         if (fs_s) begin
            fs_cnt++; checks++;
            if ({qh_s, qv_s} !== 20'd0) begin
               errors++; $display("FAIL small_fs_pos got qh=%0d qv=%0d exp 0 0", qh_s, qv_s);
            end
         end
         if (qh_s > maxqh) maxqh = qh_s;
         if (qv_s > maxqv) maxqv = qv_s;
      end
      checks++;
      if ({maxqh, maxqv} !== {10'd7, 10'd4}) begin
         errors++; $display("FAIL small_wrap got %0d/%0d exp 7/4", maxqh, maxqv);
      end
      checks++;
      if (fs_cnt != 3) begin
         errors++; $display("FAIL small_fs_count got %0d exp 3", fs_cnt);
      end
      for (int c = 0; c < 300; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_s !== exp_s) begin
            errors++; $display("FAIL small_rand_model c=%0d got %h exp %h", c, obs_s, exp_s);
         end
         en_s = ($urandom_range(0, 2) != 0);
      end
      #2;
      rst_s = 1'b1;
      #1;
      checks++;
      if (obs_s !== 26'd0) begin
         errors++; $display("FAIL small_areset got %h exp 0", obs_s);
      end
      @(negedge reloj);
      rst_s = 1'b0; en_s = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge reloj);
         checks++;
         if (obs_s !== exp_s) begin
            errors++; $display("FAIL small_restart c=%0d got %h exp %h", c, obs_s, exp_s);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_ticks();
      test_one_line();
      test_enable_hold();
      test_random_enable();
      test_async_reset();
      test_small_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage of the VGA path. Divides the system clock `reloj` down to a pixel-rate enable.
- Maintains the horizontal and vertical pixel counters `Qh` and `Qv`. Produces the `H_ON` and `V_ON` active-area flags and the `hsync`/`vsync` pulses.
- `Qh`, `Qv`, `H_ON` and `V_ON` feed the RGB colour/border stage directly. That stage assumes a 640x480 active window at `Qh` 48..687 and `Qv` 35..514.

Parameters:
- `DIV`, 4: `reloj` cycles per pixel (100 MHz to 25 MHz); must be at least 2.
- `H_BP`, 48: horizontal back porch, in pixels. Counter origin is the start of the back porch.
- `H_ACT`, 640: horizontal active pixels.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `V_BP`, 35: vertical back porch, in lines.
- `V_ACT`, 480: vertical active lines.
- `V_FP`, 8: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `SYNC_POL`, 0: active level of `hsync`/`vsync` (0 = active-low).

Ports:
- `reloj` in 1: system clock, the single clock.
- `resetM` in 1: asynchronous, active-high reset.
- `en` in 1: run enable. When 0, counters and outputs hold their values.
- `Qh` out 10: horizontal pixel counter, range 0..H_TOTAL-1.
- `Qv` out 10: vertical line counter, range 0..V_TOTAL-1.
- `H_ON` out 1: 1 while `Qh` is in the active region.
- `V_ON` out 1: 1 while `Qv` is in the active region.
- `hsync` out 1: horizontal sync, at polarity `SYNC_POL`.
- `vsync` out 1: vertical sync, at polarity `SYNC_POL`.
- `pixel_tick` out 1: one-`reloj` pulse marking each pixel advance.
- `frame_start` out 1: one-`reloj` pulse when `Qh` and `Qv` both become 0.

Behaviour:
- Derived constants:
  - H_TOTAL = H_BP+H_ACT+H_FP+H_SYNC (800).
  - V_TOTAL = V_BP+V_ACT+V_FP+V_SYNC (525).
- Reset (asynchronous, immediate, independent of `reloj`):
  - Divider counter = 0; `Qh` = 0; `Qv` = 0.
  - `H_ON` = 0; `V_ON` = 0; `pixel_tick` = 0; `frame_start` = 0.
  - `hsync` = `vsync` = ~SYNC_POL (inactive).
- Divider:
  - Counts 0..DIV-1 on each `reloj` edge with `en` = 1, then wraps to 0.
  - The internal tick is asserted when the divider equals DIV-1.
  - `pixel_tick` is the registered copy of the tick, so it is high for exactly one `reloj` cycle every DIV cycles.
- Counter advance, on each tick:
  - `Qh` = `Qh`+1.
  - If `Qh` was H_TOTAL-1, `Qh` = 0 and `Qv` advances: `Qv`+1, or 0 if `Qv` was V_TOTAL-1.
  - `Qv` changes only on the tick where `Qh` wraps.
- Decode (all outputs registered, never combinational from counter outputs):
  - Flags are computed from the next counter values and update on the same edge as the counters. Zero latency relative to `Qh`/`Qv`.
  - `H_ON` = 1 iff H_BP <= `Qh` <= H_BP+H_ACT-1 (48..687).
  - `V_ON` = 1 iff V_BP <= `Qv` <= V_BP+V_ACT-1 (35..514).
  - `hsync` is active iff `Qh` >= H_BP+H_ACT+H_FP (704..799).
  - `vsync` is active iff `Qv` >= V_BP+V_ACT+V_FP (523..524).
  - `frame_start` = 1 for one `reloj` cycle, on the edge where `Qh` and `Qv` both transition to 0.
- Enable:
  - `en` = 0 freezes the divider, counters, flags and syncs; `pixel_tick` and `frame_start` are forced to 0.
  - Resuming continues from the exact held state.
- Width rule: 10-bit counters. Compare against the constants at full width; no truncation. Parameter totals must be <= 1023.
- Reset mid-line or mid-frame: all state returns to the reset values asynchronously. The first tick after release occurs DIV cycles later and gives `Qh` = 1.
- Simultaneous events:
  - The H wrap and V wrap on the same tick give `Qh` = 0, `Qv` = 0 and `frame_start` = 1 together.
  - `en` falling on a tick cycle suppresses that tick.

Test Plan:
- Reset release, `en` = 1, DIV = 4 -> `pixel_tick` first high at `reloj` cycle 4 after release. `Qh` = 1 then, `Qh` = 2 at cycle 8. `hsync` = `vsync` = 1.
- Run one line -> `H_ON` rises exactly when `Qh` = 48 and falls when `Qh` = 688. `hsync` is low for `Qh` 704..799 (96 ticks = 384 `reloj` cycles). `Qh` wraps 799->0 and `Qv` increments 0->1 on the same edge.
- Run a full frame -> `V_ON` is high for `Qv` 35..514. `vsync` is low for `Qv` 523..524. `frame_start` pulses once per 800*525*4 = 1,680,000 `reloj` cycles, coincident with `Qh` = `Qv` = 0.
- Assert `resetM` asynchronously mid-frame (`Qh` = 300, `Qv` = 200, between edges) -> all outputs take their reset values before the next `reloj` edge. Counting restarts cleanly after release.
- `en` low for 37 cycles at `Qh` = 100 -> `Qh`, `Qv` and the flags hold. `pixel_tick` stays 0. After `en` rises, `Qh` = 101 follows the resumed divider at the correct DIV spacing.
- SYNC_POL = 1 with H_BP = 2, H_ACT = 4, H_FP = 1, H_SYNC = 1, V_BP = 1, V_ACT = 2, V_FP = 1, V_SYNC = 1 -> `hsync` is high only at `Qh` = 7, `vsync` is high only at `Qv` = 4, and H_TOTAL/V_TOTAL wrap at 8/5.
